// File: rtl/cmd_arb.sv
// cmd_arb: arbitrates the cmd_proc command port between the UART command
// source and the tour move sequencer, hands the granted command over with a
// cmd_rdy/clr_cmd_rdy handshake, waits for completion and forwards the
// completion byte (A5 done, 5A move in progress) to the UART transmitter.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   ucmd/ucmd_vld     UART command word and level request; ucmd_clr pulses on grant
//   tcmd/tcmd_vld     tour move word and level request; tcmd_last marks the final move;
//                     tcmd_ack pulses on grant
//   cmd/cmd_rdy       registered command and valid to cmd_proc
//   clr_cmd_rdy       cmd_proc accepted the command
//   send_resp         cmd_proc finished the command
//   resp/resp_trmt    response byte and one-cycle transmit strobe to the UART
//   resp_sent         UART finished transmitting the response
//   tour_active       tour lock: UART requests are held off while set
//   timeout           one-cycle pulse when a command is abandoned
module cmd_arb #(
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ucmd,
  input  logic        ucmd_vld,
  output logic        ucmd_clr,
  input  logic [15:0] tcmd,
  input  logic        tcmd_vld,
  input  logic        tcmd_last,
  output logic        tcmd_ack,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        resp_trmt,
  input  logic        resp_sent,
  output logic        tour_active,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_owner_tour;
  logic            r_last;
  logic [TO_W-1:0] r_cnt;
  logic [15:0]     r_cmd;
  logic            r_cmd_rdy;
  logic [7:0]      r_resp;
  logic            r_resp_trmt;
  logic            r_tour_active;
  logic            r_timeout;

  logic            w_grant_t;
  logic            w_grant_u;
  logic            w_expire;
  logic            w_tour_done;
  logic [7:0]      w_resp_val;

  always_comb begin
    w_grant_t   = (r_state == ST_IDLE) & tcmd_vld;
    // UART loses to the tour and is locked out for the whole tour
    w_grant_u   = (r_state == ST_IDLE) & ~tcmd_vld & ucmd_vld & ~r_tour_active;
    w_tour_done = (r_state == ST_RESP) & resp_sent & r_owner_tour & r_last;
    w_resp_val  = (!r_owner_tour || r_last) ? 8'hA5 : 8'h5A;
    w_expire    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_t || w_grant_u) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (clr_cmd_rdy) begin
          w_state_nxt = send_resp ? ST_RESP : ST_BUSY;
        end else if (!send_resp && r_cnt == TO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (send_resp) begin
          w_state_nxt = ST_RESP;
        end else if (!clr_cmd_rdy && r_cnt == TO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_sent) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner_tour  <= 1'b0;
      r_last        <= 1'b0;
      r_cnt         <= '0;
      r_cmd         <= '0;
      r_cmd_rdy     <= 1'b0;
      r_resp        <= '0;
      r_resp_trmt   <= 1'b0;
      r_tour_active <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timeout   <= w_expire;
      r_resp_trmt <= (r_state != ST_RESP) && (w_state_nxt == ST_RESP);

      if (w_grant_t || w_grant_u) begin
        r_cmd        <= w_grant_t ? tcmd : ucmd;
        r_owner_tour <= w_grant_t;
        if (w_grant_t) r_last <= tcmd_last;
        r_cnt        <= '0;
        r_cmd_rdy    <= 1'b1;
      end else if (r_state == ST_GRANT || r_state == ST_BUSY) begin
        if (r_cnt != TIMEOUT) r_cnt <= r_cnt + TO_W'(1);
        if (w_expire || (r_state == ST_GRANT && clr_cmd_rdy)) r_cmd_rdy <= 1'b0;
      end

      // resp is loaded once on entry and then held for the whole RESP stay
      if (r_state != ST_RESP && w_state_nxt == ST_RESP) r_resp <= w_resp_val;

      if (w_grant_t) begin
        r_tour_active <= 1'b1;
      end else if (w_expire || w_tour_done) begin
        r_tour_active <= 1'b0;
      end
    end
  end

  // Grant strobes are combinational so the requester sees consumption in the
  // grant cycle; gated by rst so every output reads 0 during reset.
  assign tcmd_ack    = w_grant_t & ~rst;
  assign ucmd_clr    = w_grant_u & ~rst;
  assign cmd         = r_cmd;
  assign cmd_rdy     = r_cmd_rdy;
  assign resp        = r_resp;
  assign resp_trmt   = r_resp_trmt;
  assign tour_active = r_tour_active;
  assign timeout     = r_timeout;

endmodule
